// File: rtl/rb_param.sv
// Parametrised register bank: two combinational read ports, one write port,
// optional zero register and write bypass, plus a sequential bulk-clear engine.
module rb_param #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RW,
    input  logic [ADDR_W-1:0] wR,
    input  logic [WIDTH-1:0]  wD,
    input  logic [ADDR_W-1:0] RR1,
    input  logic [ADDR_W-1:0] RR2,
    output logic [WIDTH-1:0]  RD1,
    output logic [WIDTH-1:0]  RD2,
    input  logic              CLR,
    output logic              BUSY,
    output logic              CLR_DONE,
    output logic              WR_DROP
);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              busy_q;
    logic              done_q;
    logic              drop_q;
    logic              wr_drop_d;
    logic              wr_commit;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    always_comb begin
        wr_commit = RW && (state_q == S_IDLE) && in_range(wR) && !(ZERO_REG && (wR == '0));
        // Writes to the hard-wired zero register are silently discarded, not flagged.
        wr_drop_d = RW && ((state_q != S_IDLE) || !in_range(wR));
    end

    function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] a);
        logic [WIDTH-1:0] v;
        v = '0;
        if (in_range(a) && !(ZERO_REG && (a == '0))) begin
            if (BYPASS && wr_commit && (wR == a)) v = wD;
            else                                   v = mem_q[a];
        end
        return v;
    endfunction

    always_comb begin
        RD1 = read_port(RR1);
        RD2 = read_port(RR2);
    end

    // A commit can only happen in IDLE, so it never collides with a clear sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (wr_commit)           mem_q[wR]    <= wD;
            if (state_q == S_CLEAR)  mem_q[cnt_q] <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            drop_q <= wr_drop_d;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (CLR) begin
                        state_q <= S_CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (cnt_q == LAST_IDX) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + ADDR_W'(1);
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign BUSY     = busy_q;
    assign CLR_DONE = done_q;
    assign WR_DROP  = drop_q;

endmodule

// File: tb/tb_rb_param.sv
// Bench for rb_param: three configurations (default, no bypass, DEPTH=20) on shared stimulus.
module tb_rb_param;

    localparam int unsigned NI = 3;
    localparam int unsigned DEP [NI] = '{32, 32, 20};
    localparam bit          BYP [NI] = '{1'b1, 1'b0, 1'b1};

    logic        clk;
    logic        rst_n;
    logic        RW;
    logic [4:0]  wR;
    logic [31:0] wD;
    logic [4:0]  RR1;
    logic [4:0]  RR2;
    logic        CLR;
    logic [31:0] rd1 [NI];
    logic [31:0] rd2 [NI];
    logic        busy [NI];
    logic        cdone [NI];
    logic        wdrop [NI];

    int n_vec = 0;
    int n_err = 0;

    rb_param #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_byp (
        .clk(clk), .rst_n(rst_n), .RW(RW), .wR(wR), .wD(wD), .RR1(RR1), .RR2(RR2),
        .RD1(rd1[0]), .RD2(rd2[0]), .CLR(CLR), .BUSY(busy[0]), .CLR_DONE(cdone[0]), .WR_DROP(wdrop[0]));
    rb_param #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_nobyp (
        .clk(clk), .rst_n(rst_n), .RW(RW), .wR(wR), .wD(wD), .RR1(RR1), .RR2(RR2),
        .RD1(rd1[1]), .RD2(rd2[1]), .CLR(CLR), .BUSY(busy[1]), .CLR_DONE(cdone[1]), .WR_DROP(wdrop[1]));
    rb_param #(.WIDTH(32), .DEPTH(20), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_d20 (
        .clk(clk), .rst_n(rst_n), .RW(RW), .wR(wR), .wD(wD), .RR1(RR1), .RR2(RR2),
        .RD1(rd1[2]), .RD2(rd2[2]), .CLR(CLR), .BUSY(busy[2]), .CLR_DONE(cdone[2]), .WR_DROP(wdrop[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: register contents plus "clear in progress / swept so far".
    logic [31:0] mdl [NI][32];
    bit          clearing [NI];
    bit          done_now [NI];
    bit          drop_m [NI];
    int unsigned swept [NI];

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 32; i++) mdl[k][i] = '0;
            clearing[k] = 1'b0;
            done_now[k] = 1'b0;
            drop_m[k]   = 1'b0;
            swept[k]    = 0;
        end
    endtask

    function automatic bit wcommit(input int k);
        return rst_n && RW && !clearing[k] && !done_now[k] && (wR < DEP[k]) && (wR != 0);
    endfunction

    function automatic logic [31:0] mread(input int k, input logic [4:0] a);
        if (!rst_n) return '0;
        if ((a >= DEP[k]) || (a == 0)) return '0;
        if (BYP[k] && wcommit(k) && (wR == a)) return wD;
        return mdl[k][a];
    endfunction

    task automatic model_update();
        bit idle;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < NI; k++) begin
            idle = !clearing[k] && !done_now[k];
            drop_m[k] = RW && (!idle || (wR >= DEP[k]));
            if (wcommit(k)) mdl[k][wR] = wD;
            if (clearing[k]) begin
                mdl[k][swept[k]] = '0;
                swept[k]++;
                if (swept[k] == DEP[k]) begin
                    clearing[k] = 1'b0;
                    done_now[k] = 1'b1;
                end
            end else if (done_now[k]) begin
                done_now[k] = 1'b0;
            end else if (CLR) begin
                clearing[k] = 1'b1;
                swept[k]    = 0;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("model rd1[%0d]", k), rd1[k], mread(k, RR1));
            chk($sformatf("model rd2[%0d]", k), rd2[k], mread(k, RR2));
            chk($sformatf("model busy[%0d]", k), 32'(busy[k]), 32'(clearing[k]));
            chk($sformatf("model clr_done[%0d]", k), 32'(cdone[k]), 32'(done_now[k]));
            chk($sformatf("model wr_drop[%0d]", k), 32'(wdrop[k]), 32'(drop_m[k]));
        end
    endtask

    task automatic settle();
        #1;
        check_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        RW = 1'b0; wR = '0; wD = '0; CLR = 1'b0;
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        settle();
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("reset busy[%0d]", k), 32'(busy[k]), 32'd0);
            chk($sformatf("reset clr_done[%0d]", k), 32'(cdone[k]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic [31:0] e1b;
        logic [31:0] e1n;
        logic [31:0] e2;
        logic        edrop;
    } vec_t;

    vec_t tbl [9];
    int   busy_cnt;
    int   done_at;

    initial begin
        tbl[0] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'h0,        32'h0,        32'h0,        1'b0};
        tbl[1] = '{1'b1, 5'd3,  32'hDEADBEEF, 5'd3,  5'd31, 32'hDEADBEEF, 32'h0,        32'h0,        1'b0};
        tbl[2] = '{1'b0, 5'd3,  32'h0,        5'd3,  5'd3,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        tbl[3] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd3,  32'h0,        32'h0,        32'hDEADBEEF, 1'b0};
        tbl[4] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        1'b0};
        tbl[5] = '{1'b1, 5'd31, 32'h55,       5'd31, 5'd30, 32'h55,       32'h0,        32'h0,        1'b0};
        tbl[6] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd3,  32'h55,       32'h55,       32'hDEADBEEF, 1'b0};
        tbl[7] = '{1'b1, 5'd3,  32'h11,       5'd3,  5'd31, 32'h11,       32'hDEADBEEF, 32'h55,       1'b0};
        tbl[8] = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd0,  32'h11,       32'h11,       32'h0,        1'b0};

        rst_n = 1'b0;
        idle_inputs();
        RR1 = 5'd5; RR2 = 5'd31;
        model_reset();
        @(negedge clk);
        settle();
        chk("reset rd1", rd1[0], 32'h0);
        chk("reset rd2", rd2[0], 32'h0);
        chk("reset busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 9; v++) begin
            RW = tbl[v].rw; wR = tbl[v].wr; wD = tbl[v].wd;
            RR1 = tbl[v].rr1; RR2 = tbl[v].rr2;
            settle();
            chk($sformatf("tbl%0d rd1 bypass", v), rd1[0], tbl[v].e1b);
            chk($sformatf("tbl%0d rd1 nobypass", v), rd1[1], tbl[v].e1n);
            chk($sformatf("tbl%0d rd2 bypass", v), rd2[0], tbl[v].e2);
            chk($sformatf("tbl%0d rd2 nobypass", v), rd2[1], tbl[v].e2);
            chk($sformatf("tbl%0d wr_drop", v), 32'(wdrop[0]), 32'(tbl[v].edrop));
            tick();
        end

        // Bulk clear with preload reg[i]=i+1 and a write issued mid-clear.
        for (int i = 0; i < 32; i++) begin
            RW = 1'b1; wR = 5'(i); wD = 32'(i + 1); RR1 = 5'(i); RR2 = 5'd7;
            settle();
            tick();
        end
        idle_inputs();
        CLR = 1'b1;
        settle();
        tick();
        CLR = 1'b0;
        busy_cnt = 0;
        done_at  = 0;
        for (int c = 1; c <= 40; c++) begin
            RW = (c == 5); wR = 5'd7; wD = 32'hAA; RR1 = 5'd7; RR2 = 5'(c % 32);
            settle();
            if (busy[0]) busy_cnt++;
            if (cdone[0] && (done_at == 0)) done_at = c;
            if (c == 6) chk("mid-clear wr_drop", 32'(wdrop[0]), 32'd1);
            tick();
        end
        chk("clear busy cycles", 32'(busy_cnt), 32'd32);
        chk("clear done cycle", 32'(done_at), 32'd33);
        idle_inputs();
        for (int i = 0; i < 32; i++) begin
            RR1 = 5'(i); RR2 = 5'(31 - i);
            settle();
            chk($sformatf("post-clear reg%0d", i), rd1[0], 32'h0);
            tick();
        end

        // Reset during clear on the DEPTH=20 instance, then out-of-range access.
        for (int i = 1; i < 20; i++) begin
            RW = 1'b1; wR = 5'(i); wD = 32'(100 + i);
            settle();
            tick();
        end
        idle_inputs();
        CLR = 1'b1;
        settle();
        tick();
        CLR = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            RR1 = 5'(c); RR2 = 5'(19 - c);
            settle();
            tick();
        end
        chk("busy before reset", 32'(busy[2]), 32'd1);
        async_reset();
        for (int c = 0; c < 25; c++) begin
            RR1 = 5'(c % 20); RR2 = 5'(19 - (c % 20));
            settle();
            chk("no clr_done after reset", 32'(cdone[2]), 32'd0);
            chk("reg zero after reset", rd1[2], 32'h0);
            tick();
        end
        RW = 1'b1; wR = 5'd25; wD = 32'h77;
        settle();
        tick();
        RW = 1'b0; RR2 = 5'd25;
        settle();
        chk("d20 out-of-range wr_drop", 32'(wdrop[2]), 32'd1);
        chk("d20 out-of-range rd2", rd2[2], 32'h0);
        tick();

        // Randomised traffic against the model.
        for (int c = 0; c < 600; c++) begin
            RW  = 1'($urandom_range(0, 1));
            wR  = 5'($urandom_range(0, 31));
            wD  = $urandom;
            RR1 = ($urandom_range(0, 3) == 0) ? wR : 5'($urandom_range(0, 31));
            RR2 = 5'($urandom_range(0, 31));
            CLR = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 199) == 0) async_reset();
            else begin
                settle();
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
